// File: rtl/posit_result_monitor.sv
// rtl/posit_result_monitor.sv - statistics monitor comparing posit adder results against golden values
// Optional histogram outputs are enabled by defining POSIT_MON_HIST_EN.
module posit_result_monitor #(
   parameter int N       = 8,
   parameter int NUM_VEC = 65536,
   parameter int CW      = 32,
   parameter int TOL     = 0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            in_valid,
   input  logic [N-1:0]    dut_out,
   input  logic [N-1:0]    exp_out,
   output logic            busy,
   output logic            done,
   output logic [CW-1:0]   vec_count,
   output logic [CW-1:0]   fail_count,
   output logic [N-1:0]    max_diff,
   output logic [CW+N-1:0] diff_sum,
   output logic [CW-1:0]   first_fail_idx,
`ifdef POSIT_MON_HIST_EN
   output logic [CW-1:0]   hist0,
   output logic [CW-1:0]   hist1,
   output logic [CW-1:0]   hist2,
   output logic [CW-1:0]   hist3,
`endif
   output logic            first_fail_vld
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   // 64-bit forms keep the compares correct even when NUM_VEC/TOL exceed CW/N bits.
   localparam logic [63:0] NUM_VEC_W = 64'(NUM_VEC);
   localparam logic [63:0] TOL_W     = 64'(TOL);

   state_t            state_q;
   logic              busy_q, done_q;
   logic [CW-1:0]     vec_count_q, fail_count_q, first_fail_idx_q;
   logic [N-1:0]      max_diff_q;
   logic [CW+N-1:0]   diff_sum_q;
   logic              first_fail_vld_q;

   logic [N-1:0]      diff;
   logic              is_fail, accept, is_last;
   logic [CW-1:0]     vec_count_d, fail_count_d;
   logic [N-1:0]      max_diff_d;
   logic [CW+N:0]     sum_ext;
   logic [CW+N-1:0]   diff_sum_d;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (&v) ? v : v + CW'(1);
   endfunction

   always_comb begin
      diff         = (exp_out > dut_out) ? exp_out - dut_out : dut_out - exp_out;
      is_fail      = 64'(diff) > TOL_W;
      accept       = (state_q == RUN) && in_valid && !start;
      is_last      = (64'(vec_count_q) + 64'd1) == NUM_VEC_W;
      vec_count_d  = sat_inc(vec_count_q);
      fail_count_d = is_fail ? sat_inc(fail_count_q) : fail_count_q;
      max_diff_d   = (diff > max_diff_q) ? diff : max_diff_q;
      sum_ext      = {1'b0, diff_sum_q} + (CW+N+1)'(diff);
      diff_sum_d   = sum_ext[CW+N] ? {(CW+N){1'b1}} : sum_ext[CW+N-1:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q          <= IDLE;
         busy_q           <= 1'b0;
         done_q           <= 1'b0;
         vec_count_q      <= '0;
         fail_count_q     <= '0;
         max_diff_q       <= '0;
         diff_sum_q       <= '0;
         first_fail_idx_q <= '0;
         first_fail_vld_q <= 1'b0;
      end else if (start) begin
         state_q          <= RUN;
         busy_q           <= 1'b1;
         done_q           <= 1'b0;
         vec_count_q      <= '0;
         fail_count_q     <= '0;
         max_diff_q       <= '0;
         diff_sum_q       <= '0;
         first_fail_idx_q <= '0;
         first_fail_vld_q <= 1'b0;
      end else if (accept) begin
         vec_count_q  <= vec_count_d;
         fail_count_q <= fail_count_d;
         max_diff_q   <= max_diff_d;
         diff_sum_q   <= diff_sum_d;
         if (is_fail && !first_fail_vld_q) begin
            first_fail_idx_q <= vec_count_q;
            first_fail_vld_q <= 1'b1;
         end
         if (is_last) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
         end
      end
   end

`ifdef POSIT_MON_HIST_EN
   logic [CW-1:0] hist_q [4];
   logic [1:0]    hist_sel;

   always_comb begin
      hist_sel = (diff >= N'(3)) ? 2'd3 : diff[1:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset || start) begin
         for (int i = 0; i < 4; i++) hist_q[i] <= '0;
      end else if (accept) begin
         hist_q[hist_sel] <= sat_inc(hist_q[hist_sel]);
      end
   end

   assign hist0 = hist_q[0];
   assign hist1 = hist_q[1];
   assign hist2 = hist_q[2];
   assign hist3 = hist_q[3];
`endif

   assign busy           = busy_q;
   assign done           = done_q;
   assign vec_count      = vec_count_q;
   assign fail_count     = fail_count_q;
   assign max_diff       = max_diff_q;
   assign diff_sum       = diff_sum_q;
   assign first_fail_idx = first_fail_idx_q;
   assign first_fail_vld = first_fail_vld_q;

endmodule

// File: tb/tb_posit_result_monitor.sv
// tb/tb_posit_result_monitor.sv - directed self-checking bench for posit_result_monitor
// Three instances share stimulus: NUM_VEC=4/TOL=0, NUM_VEC=16/TOL=1, and CW=2 for saturation.
module tb_posit_result_monitor;

   logic       clk = 1'b0;
   logic       reset, start, in_valid;
   logic [7:0] dut_out, exp_out;
   int         checks = 0;
   int         failures = 0;

   logic        busy0, done0, ffv0;
   logic [31:0] vc0, fc0, ffi0;
   logic [7:0]  md0;
   logic [39:0] ds0;
   logic        busy1, done1, ffv1;
   logic [31:0] vc1, fc1, ffi1;
   logic [7:0]  md1;
   logic [39:0] ds1;
   logic        busy2, done2, ffv2;
   logic [1:0]  vc2, fc2, ffi2;
   logic [7:0]  md2;
   logic [9:0]  ds2;
`ifdef POSIT_MON_HIST_EN
   logic [31:0] h00, h01, h02, h03, h10, h11, h12, h13;
   logic [1:0]  h20, h21, h22, h23;
`endif

   always #5 clk = ~clk;

   posit_result_monitor #(.N(8), .NUM_VEC(4), .CW(32), .TOL(0)) dut0 (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
      .dut_out(dut_out), .exp_out(exp_out), .busy(busy0), .done(done0),
      .vec_count(vc0), .fail_count(fc0), .max_diff(md0), .diff_sum(ds0),
      .first_fail_idx(ffi0),
`ifdef POSIT_MON_HIST_EN
      .hist0(h00), .hist1(h01), .hist2(h02), .hist3(h03),
`endif
      .first_fail_vld(ffv0));

   posit_result_monitor #(.N(8), .NUM_VEC(16), .CW(32), .TOL(1)) dut1 (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
      .dut_out(dut_out), .exp_out(exp_out), .busy(busy1), .done(done1),
      .vec_count(vc1), .fail_count(fc1), .max_diff(md1), .diff_sum(ds1),
      .first_fail_idx(ffi1),
`ifdef POSIT_MON_HIST_EN
      .hist0(h10), .hist1(h11), .hist2(h12), .hist3(h13),
`endif
      .first_fail_vld(ffv1));

   posit_result_monitor #(.N(8), .NUM_VEC(8), .CW(2), .TOL(0)) dut2 (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
      .dut_out(dut_out), .exp_out(exp_out), .busy(busy2), .done(done2),
      .vec_count(vc2), .fail_count(fc2), .max_diff(md2), .diff_sum(ds2),
      .first_fail_idx(ffi2),
`ifdef POSIT_MON_HIST_EN
      .hist0(h20), .hist1(h21), .hist2(h22), .hist3(h23),
`endif
      .first_fail_vld(ffv2));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic v, input logic [7:0] d, input logic [7:0] e);
      in_valid = v;
      dut_out  = d;
      exp_out  = e;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // The start cycle carries a valid sample that must be ignored.
   task automatic do_start();
      start    = 1'b1;
      in_valid = 1'b1;
      dut_out  = 8'h00;
      exp_out  = 8'hFF;
      @(posedge clk);
      #1;
      start    = 1'b0;
      in_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; in_valid = 1'b0; dut_out = '0; exp_out = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy0, 0);
      chk("rst_done", done0, 0);
      chk("rst_vec", vc0, 0);
      chk("rst_fail", fc0, 0);
      chk("rst_max", md0, 0);
      chk("rst_sum", ds0, 0);
      chk("rst_ffvld", ffv0, 0);
      chk("rst_ffidx", ffi0, 0);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("idle_busy", busy0, 0);

      // All-equal run of exactly NUM_VEC samples
      do_start();
      chk("start_busy", busy0, 1);
      chk("start_ignored_vec", vc0, 0);
      for (int i = 0; i < 4; i++) cyc(1'b1, 8'h40, 8'h40);
      chk("eq_done", done0, 1);
      chk("eq_busy", busy0, 0);
      chk("eq_vec", vc0, 4);
      chk("eq_fail", fc0, 0);
      chk("eq_max", md0, 0);
      chk("eq_sum", ds0, 0);
      chk("eq_ffvld", ffv0, 0);

      // Mixed diffs 3,1,0,0x80 with in_valid gaps
      do_start();
      cyc(1'b1, 8'h40, 8'h43);
      chk("lat_vec", vc0, 1);
      chk("lat_sum", ds0, 3);
      cyc(1'b0, 8'h00, 8'hFF);
      cyc(1'b1, 8'h50, 8'h4F);
      cyc(1'b0, 8'h00, 8'hFF);
      cyc(1'b0, 8'h00, 8'hFF);
      cyc(1'b1, 8'h10, 8'h10);
      chk("gap_busy", busy0, 1);
      cyc(1'b1, 8'hC0, 8'h40);
      chk("mix_done", done0, 1);
      chk("mix_vec", vc0, 4);
      chk("mix_fail", fc0, 3);
      chk("mix_max", md0, 8'h80);
      chk("mix_sum", ds0, 40'h84);
      chk("mix_ffidx", ffi0, 0);
      chk("mix_ffvld", ffv0, 1);
      chk("tol_fail", fc1, 2);
      chk("tol_ffidx", ffi1, 0);
      chk("tol_ffvld", ffv1, 1);
      chk("tol_vec", vc1, 4);
      chk("tol_busy", busy1, 1);

      // Samples in DONE are ignored; start in DONE clears everything
      for (int i = 0; i < 3; i++) cyc(1'b1, 8'h00, 8'h7F);
      chk("done_hold_vec", vc0, 4);
      chk("done_hold_sum", ds0, 40'h84);
      chk("done_hold_max", md0, 8'h80);
      do_start();
      chk("restart_busy", busy0, 1);
      chk("restart_done", done0, 0);
      chk("restart_vec", vc0, 0);
      chk("restart_fail", fc0, 0);
      chk("restart_max", md0, 0);
      chk("restart_sum", ds0, 0);
      chk("restart_ffvld", ffv0, 0);
      chk("restart_ffidx", ffi0, 0);

      // Asynchronous reset after 10 vectors
      for (int i = 0; i < 10; i++) cyc(1'b1, 8'h00, 8'h02);
      chk("pre_rst_vec", vc1, 10);
      chk("pre_rst_fail", fc1, 10);
      chk("pre_rst_sum", ds1, 20);
      #2 reset = 1'b1;
      #1;
      chk("arst_busy", busy1, 0);
      chk("arst_vec", vc1, 0);
      chk("arst_fail", fc1, 0);
      chk("arst_sum", ds1, 0);
      chk("arst_max", md1, 0);
      chk("arst_ffvld", ffv1, 0);
      #8 reset = 1'b0;
      @(posedge clk);
      #1;
      chk("post_rst_idle", busy1, 0);
      cyc(1'b1, 8'h05, 8'h09);
      chk("idle_ignored_vec", vc1, 0);
      do_start();
      cyc(1'b1, 8'h05, 8'h05);
      chk("new_run_vec", vc1, 1);
      chk("new_run_fail", fc1, 0);
      chk("new_run_busy", busy1, 1);

      // Saturation on the CW=2 instance
      do_start();
      for (int i = 0; i < 5; i++) cyc(1'b1, 8'h00, 8'hFF);
      chk("sat_vec", vc2, 2'b11);
      chk("sat_fail", fc2, 2'b11);
      chk("sat_sum", ds2, 10'h3FF);
      chk("sat_max", md2, 8'hFF);
      chk("sat_ffidx", ffi2, 0);
      chk("sat_busy", busy2, 1);
      chk("sat_done", done2, 0);

`ifdef POSIT_MON_HIST_EN
      do_start();
      cyc(1'b1, 8'h20, 8'h20);
      cyc(1'b1, 8'h20, 8'h21);
      cyc(1'b1, 8'h22, 8'h20);
      cyc(1'b1, 8'h20, 8'h25);
      cyc(1'b1, 8'h33, 8'h33);
      chk("hist0", h10, 2);
      chk("hist1", h11, 1);
      chk("hist2", h12, 1);
      chk("hist3", h13, 1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
